pipelined_addsub: RTL and testbench

- Parametrised, pipelined WIDTH-bit adder/subtractor; successor to the single-cycle ripple adder in the ALU.
- Carry chain split into STAGES equal chunks, one chunk per register stage; operands and partial sums skewed through the pipe.
- Valid/ready handshake on input and output with full backpressure.
- Reports carry-out and signed overflow; the old adder dropped both.

---
 rtl/pipelined_addsub_if.sv | 26 ++
 rtl/pipelined_addsub.sv | 123 ++++++++++++
 tb/tb_pipelined_addsub.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The master drives operands and consumes results; the slave is the adder.
interface pipelined_addsub_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output i1, i2, sub, in_valid, out_ready,
    input  in_ready, out, carry_out, overflow, out_valid
  );

  modport slave (
    input  i1, i2, sub, in_valid, out_ready,
    output in_ready, out, carry_out, overflow, out_valid
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, carry chain cut into STAGES equal chunks.
// Define PIPELINED_ADDSUB_SAT_EN to saturate the result on signed overflow.
module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave bus
);
  localparam int CHUNK = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("pipelined_addsub: illegal WIDTH/STAGES combination");
  end

  logic             adv;
  logic [WIDTH-1:0] b_in;

  // The whole pipe advances together whenever the output slot can be refilled.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign b_in         = bus.i2 ^ {WIDTH{bus.sub}};

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int SRC_W  = WIDTH - gi * CHUNK;
    localparam int DONE_W = (gi + 1) * CHUNK;
    localparam int REM_W  = SRC_W - CHUNK;

    logic              valid_reg;
    logic              carry_reg;
    logic              a_msb_reg;
    logic              b_msb_reg;
    logic [DONE_W-1:0] res_reg;

    logic              src_valid;
    logic              src_carry;
    logic              src_a_msb;
    logic              src_b_msb;
    logic [SRC_W-1:0]  src_a;
    logic [SRC_W-1:0]  src_b;
    logic [DONE_W-1:0] res_next;
    logic [CHUNK:0]    chunk_sum;

    // Low CHUNK bits of the still-unprocessed operands are this stage's slice.
    assign chunk_sum = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, src_carry};

    if (gi == 0) begin : g_src
      assign src_valid = bus.in_valid;
      assign src_carry = bus.sub;
      assign src_a_msb = bus.i1[WIDTH-1];
      assign src_b_msb = b_in[WIDTH-1];
      assign src_a     = bus.i1;
      assign src_b     = b_in;
      assign res_next  = chunk_sum[CHUNK-1:0];
    end else begin : g_src
      assign src_valid = g_stage[gi-1].valid_reg;
      assign src_carry = g_stage[gi-1].carry_reg;
      assign src_a_msb = g_stage[gi-1].a_msb_reg;
      assign src_b_msb = g_stage[gi-1].b_msb_reg;
      assign src_a     = g_stage[gi-1].g_rem.a_rem_reg;
      assign src_b     = g_stage[gi-1].g_rem.b_rem_reg;
      assign res_next  = {chunk_sum[CHUNK-1:0], g_stage[gi-1].res_reg};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        a_msb_reg <= 1'b0;
        b_msb_reg <= 1'b0;
        res_reg   <= '0;
      end else if (adv) begin
        valid_reg <= src_valid;
        if (src_valid) begin
          carry_reg <= chunk_sum[CHUNK];
          a_msb_reg <= src_a_msb;
          b_msb_reg <= src_b_msb;
          res_reg   <= res_next;
        end
      end
    end

    // Operand bits above this chunk ride along until their own stage.
    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] a_rem_reg;
      logic [REM_W-1:0] b_rem_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem_reg <= '0;
          b_rem_reg <= '0;
        end else if (adv && src_valid) begin
          a_rem_reg <= src_a[SRC_W-1:CHUNK];
          b_rem_reg <= src_b[SRC_W-1:CHUNK];
        end
      end
    end
  end

  logic [WIDTH-1:0] res;
  logic             a_msb;
  logic             ovf;

  assign res   = g_stage[STAGES-1].res_reg;
  assign a_msb = g_stage[STAGES-1].a_msb_reg;
  // Same-signed operands producing a result of the other sign.
  assign ovf   = (a_msb == g_stage[STAGES-1].b_msb_reg) && (res[WIDTH-1] != a_msb);

  assign bus.out_valid = g_stage[STAGES-1].valid_reg;
  assign bus.carry_out = g_stage[STAGES-1].carry_reg;
  assign bus.overflow  = ovf;

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] MSB_ONLY = WIDTH'(1) << (WIDTH - 1);
  // Positive overflow clamps to 0111.., negative to 1000..
  assign bus.out = ovf ? ({WIDTH{~a_msb}} ^ MSB_ONLY) : res;
`else
  assign bus.out = res;
`endif
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed cases on an 8/2 instance, random sweeps
// on 8/2, 16/4 and 5/1 instances against a signed/unsigned arithmetic model.
module tb_pipelined_addsub;
  localparam int NOPS = 1000;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [15:0] drv_a  [3];
  logic [15:0] drv_b  [3];
  logic        drv_s  [3];
  logic        drv_iv [3];
  logic        drv_or [3];
  int          wid    [3] = '{8, 16, 5};

  pipelined_addsub_if #(.WIDTH(8))  bus8 ();
  pipelined_addsub_if #(.WIDTH(16)) bus16 ();
  pipelined_addsub_if #(.WIDTH(5))  bus5 ();

  pipelined_addsub #(.WIDTH(8),  .STAGES(2)) u8  (.clk(clk), .rst(rst), .bus(bus8));
  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u16 (.clk(clk), .rst(rst), .bus(bus16));
  pipelined_addsub #(.WIDTH(5),  .STAGES(1)) u5  (.clk(clk), .rst(rst), .bus(bus5));

  assign bus8.i1        = drv_a[0][7:0];
  assign bus8.i2        = drv_b[0][7:0];
  assign bus8.sub       = drv_s[0];
  assign bus8.in_valid  = drv_iv[0];
  assign bus8.out_ready = drv_or[0];
  assign bus16.i1        = drv_a[1];
  assign bus16.i2        = drv_b[1];
  assign bus16.sub       = drv_s[1];
  assign bus16.in_valid  = drv_iv[1];
  assign bus16.out_ready = drv_or[1];
  assign bus5.i1        = drv_a[2][4:0];
  assign bus5.i2        = drv_b[2][4:0];
  assign bus5.sub       = drv_s[2];
  assign bus5.in_valid  = drv_iv[2];
  assign bus5.out_ready = drv_or[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {in_ready, out_valid, overflow, carry_out, out[15:0]}
  function automatic logic [19:0] f_obs(input int d);
    case (d)
      0:       return {bus8.in_ready, bus8.out_valid, bus8.overflow, bus8.carry_out, 8'h00, bus8.out};
      1:       return {bus16.in_ready, bus16.out_valid, bus16.overflow, bus16.carry_out, bus16.out};
      default: return {bus5.in_ready, bus5.out_valid, bus5.overflow, bus5.carry_out, 11'h000, bus5.out};
    endcase
  endfunction

  // Returns {overflow, carry_out, out[15:0]} from integer arithmetic.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
    longint mask, half, ua, ub, sa, sb, rs, ro;
    logic   c, ov;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    if (s) begin
      c  = (ua >= ub);
      rs = sa - sb;
      ro = (ua - ub) & mask;
    end else begin
      c  = ((ua + ub) > mask);
      rs = sa + sb;
      ro = (ua + ub) & mask;
    end
    ov = (rs > half - 1) || (rs < -half);
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (ov) ro = (rs > 0) ? half - 1 : ((-half) & mask);
`endif
    return {ov, c, ro[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated op on the 8-bit/2-stage instance, out_ready held high.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [17:0] e;
    logic [19:0] o;
    e = ref_model(8, {8'h00, a}, {8'h00, b}, s);
    drv_a[0] = {8'h00, a}; drv_b[0] = {8'h00, b}; drv_s[0] = s;
    drv_iv[0] = 1'b1; drv_or[0] = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(f_obs(0) >> 19), 1);
    @(posedge clk); #1;
    drv_iv[0] = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, 32'(f_obs(0) >> 18) & 1, 0);
    @(posedge clk);
    @(negedge clk);
    o = f_obs(0);
    chk({tag, "_valid"}, 32'(o[18]), 1);
    chk({tag, "_result"}, 32'(o[17:0]), 32'(e));
    $display("op %s: a=0x%02h b=0x%02h sub=%0d -> out=0x%02h c=%0d ov=%0d", tag, a, b, s, o[7:0], o[16], o[17]);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_once"}, 32'(f_obs(0) >> 18) & 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [19:0] o;
    logic [17:0] q [3][$];
    logic [7:0]  bpq [$];
    logic [15:0] held;
    logic [15:0] msk [3];
    int          sent [3];
    int          recv [3];
    int          next_i, got, stall_left, cyc, pulses;
    bit          seen, have_held, busy;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      drv_a[d] = '0; drv_b[d] = '0; drv_s[d] = 1'b0; drv_iv[d] = 1'b0; drv_or[d] = 1'b1;
      msk[d] = 16'((32'd1 << wid[d]) - 1);
      sent[d] = 0; recv[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("rst_state_w%0d", wid[d]), 32'(f_obs(d)), 32'h80000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("post_rst_w%0d", wid[d]), 32'(f_obs(d)), 32'h80000);
    @(posedge clk); #1;

    op8("add",      8'h3C, 8'h05, 1'b0);
    op8("wrap",     8'hFF, 8'h01, 1'b0);
    op8("pos_ovf",  8'h7F, 8'h01, 1'b0);
    op8("borrow",   8'h05, 8'h07, 1'b1);
    op8("neg_ovf",  8'h80, 8'h01, 1'b1);

    // Backpressure: four ops, output stalled three cycles after the first result.
    next_i = 1; got = 0; stall_left = 0; cyc = 0; seen = 0; have_held = 0; held = '0;
    while (got < 4 && cyc < 40) begin
      if (f_obs(0)[18] && !seen) begin
        seen = 1; stall_left = 3;
      end
      drv_or[0] = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      drv_iv[0] = (next_i <= 4);
      drv_a[0] = 16'(next_i); drv_b[0] = 16'h0010; drv_s[0] = 1'b0;
      @(negedge clk);
      o = f_obs(0);
      if (o[18] && !drv_or[0]) begin
        chk("bp_in_ready_low", 32'(o[19]), 0);
        if (have_held) chk("bp_stable", 32'(o[15:0]), 32'(held));
        held = o[15:0]; have_held = 1;
      end
      if (o[18] && drv_or[0]) begin
        chk("bp_pending", 32'(bpq.size() != 0), 1);
        if (bpq.size() != 0) chk("bp_result", 32'(o[15:0]), 32'(bpq.pop_front()));
        $display("bp: out=0x%02h", o[7:0]);
        got++;
      end
      if (drv_iv[0] && o[19]) begin
        bpq.push_back(8'(16 + next_i));
        next_i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_count", 32'(got), 4);
    chk("bp_stalled", 32'(have_held), 1);
    drv_iv[0] = 1'b0; drv_or[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_no_dup", 32'(f_obs(0) >> 18) & 1, 0);
      @(posedge clk); #1;
    end

    // Reset with two ops in flight, then a fresh op right after reset.
    drv_or[0] = 1'b0; drv_iv[0] = 1'b1; drv_s[0] = 1'b0;
    drv_a[0] = 16'h0021; drv_b[0] = 16'h0002;
    @(posedge clk); #1;
    drv_a[0] = 16'h0030; drv_b[0] = 16'h0003;
    @(posedge clk); #1;
    chk("rst_pre_valid", 32'(f_obs(0) >> 18) & 1, 1);
    drv_iv[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drv_iv[0] = 1'b1; drv_or[0] = 1'b1;
    drv_a[0] = 16'h0040; drv_b[0] = 16'h0004;
    @(negedge clk);
    chk("rst_flush", 32'(f_obs(0)), 32'h80000);
    @(posedge clk); #1;
    drv_iv[0] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      o = f_obs(0);
      if (o[18]) begin
        chk("rst_new_result", 32'(o[15:0]), 32'h44);
        pulses++;
      end
      @(posedge clk); #1;
    end
    chk("rst_new_count", 32'(pulses), 1);

    // Random sweep on all three instances at once.
    cyc = 0; busy = 1;
    while (busy && cyc < 20000) begin
      for (int d = 0; d < 3; d++) begin
        drv_iv[d] = (sent[d] < NOPS) && ($urandom_range(0, 3) != 0);
        drv_a[d]  = 16'($urandom) & msk[d];
        drv_b[d]  = 16'($urandom) & msk[d];
        drv_s[d]  = 1'($urandom);
        drv_or[d] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        o = f_obs(d);
        chk($sformatf("sw%0d_in_ready", wid[d]), 32'(o[19]), 32'(!o[18] || drv_or[d]));
        if (o[18] && drv_or[d]) begin
          chk($sformatf("sw%0d_pending", wid[d]), 32'(q[d].size() != 0), 1);
          if (q[d].size() != 0) chk($sformatf("sw%0d_result", wid[d]), 32'(o[17:0]), 32'(q[d].pop_front()));
          recv[d]++;
        end
        if (drv_iv[d] && o[19]) begin
          q[d].push_back(ref_model(wid[d], drv_a[d], drv_b[d], drv_s[d]));
          sent[d]++;
        end
      end
      busy = (recv[0] < NOPS) || (recv[1] < NOPS) || (recv[2] < NOPS);
      @(posedge clk); #1;
      cyc++;
    end
    for (int d = 0; d < 3; d++) begin
      $display("sweep w=%0d: sent=%0d received=%0d", wid[d], sent[d], recv[d]);
      chk($sformatf("sw%0d_count", wid[d]), 32'(recv[d]), NOPS);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
